set_assoc_cache: RTL and testbench

Parametrised N-way set-associative read cache with an automatic line-refill engine. It generalises the existing two-entry hit-compare cache to configurable word width, set count, associativity and line length. It adds a request/response handshake, round-robin replacement and a flush. It sits between the CPU fetch/load path and main memory, and exposes a single-outstanding memory request port.

---
 rtl/set_assoc_cache.sv | 200 ++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
`default_nettype none
// set_assoc_cache: N-way set-associative read cache with a single-outstanding refill engine.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module set_assoc_cache #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int SETS       = 4,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_hit,
  input  logic                  flush,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [WIDTH-1:0]      mem_resp_data
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [OFF_W-1:0] K_LAST   = OFF_W'(LINE_WORDS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MEM_REQ   = 3'd2,
    S_MEM_WAIT  = 3'd3,
    S_FILL_DONE = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [OFF_W-1:0]      r_k;
  logic [PTR_W-1:0]      r_victim;
  logic                  r_by_ptr;
  logic                  r_flush_pend;

  logic [WAYS-1:0]  r_valid [SETS];
  logic [PTR_W-1:0] r_ptr   [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WIDTH-1:0] r_data  [SETS][WAYS][LINE_WORDS];

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [PTR_W-1:0] w_hit_way;
  logic             w_inv_found;
  logic [PTR_W-1:0] w_inv_way;
  logic             w_accept;

  assign w_off    = r_addr[OFF_W-1:0];
  assign w_idx    = r_addr[OFF_W +: IDX_W];
  assign w_tag    = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_accept = (r_state == S_IDLE) && req_valid && !flush && !r_flush_pend;

  // Descending scan so the lowest matching / lowest invalid way is the one kept.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][PTR_W'(w)] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = PTR_W'(w);
      end
      if (!r_valid[w_idx][PTR_W'(w)]) begin
        w_inv_found = 1'b1;
        w_inv_way   = PTR_W'(w);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    resp_data     = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = !flush && !r_flush_pend;
        if (w_accept) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          resp_data  = r_data[w_idx][w_hit_way][w_off];
          w_next     = S_IDLE;
        end else begin
          w_next = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {w_tag, w_idx, r_k};
        if (mem_req_ready) w_next = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_resp_valid) w_next = (r_k == K_LAST) ? S_FILL_DONE : S_MEM_REQ;
      end
      S_FILL_DONE: begin
        resp_valid = 1'b1;
        resp_data  = r_data[w_idx][r_victim][w_off];
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_k          <= '0;
      r_victim     <= '0;
      r_by_ptr     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_valid      <= '{default: '0};
      r_ptr        <= '{default: '0};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush || r_flush_pend) begin
            r_valid      <= '{default: '0};
            r_flush_pend <= 1'b0;
          end else if (req_valid) begin
            r_addr <= req_addr;
          end
        end
        S_LOOKUP: begin
          if (!w_hit) begin
            r_k      <= '0;
            r_victim <= w_inv_found ? w_inv_way : r_ptr[w_idx];
            r_by_ptr <= !w_inv_found;
          end
        end
        S_MEM_WAIT: begin
          if (mem_resp_valid && (r_k != K_LAST)) r_k <= r_k + 1'b1;
        end
        S_FILL_DONE: begin
          r_valid[w_idx][r_victim] <= 1'b1;
          if (r_by_ptr) r_ptr[w_idx] <= (r_ptr[w_idx] == PTR_LAST) ? '0 : r_ptr[w_idx] + 1'b1;
        end
        default: ;
      endcase
      if ((r_state != S_IDLE) && flush) r_flush_pend <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if ((r_state == S_MEM_WAIT) && mem_resp_valid) r_data[w_idx][r_victim][r_k] <= mem_resp_data;
    if (r_state == S_FILL_DONE) r_tag[w_idx][r_victim] <= w_tag;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (!w_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
`default_nettype none
// tb_set_assoc_cache: randomized reads against a transaction-level cache model.
module tb_set_assoc_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic        flush;
  logic        mem_req_valid;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct {
    logic        hit;
    logic [31:0] data;
    int          acc;
    int          lit;      // 0 none, 1 literal hit, 2 literal miss
    logic [31:0] lit_d;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          busy;
  bit          hwpend;
  bit          fixed_mem = 1'b1;
  int          lit_sel = 0;
  logic [31:0] lit_data = 32'h0;
  int          stats_lit_cyc = -1;

  // Model state: default geometry (4 sets, 2 ways, 2-word lines, 16-bit address).
  bit   m_valid [4][2];
  int   m_tag   [4][2];
  int   m_ptr   [4];
  int   m_hits, m_misses;
  exp_t exq[$];
  logic [15:0] emq[$];
  exp_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, ex);
    end
  endtask

  task automatic model_clear_valid();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_hit", 32'(resp_hit), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_mem_req_addr", 32'(mem_req_addr), 32'd0);
      model_clear_valid();
      for (int s = 0; s < 4; s++) m_ptr[s] = 0;
      hwpend = 1'b0;
      exq.delete();
      emq.delete();
      m_hits = 0;
      m_misses = 0;
    end else begin
      busy = (exq.size() != 0);
      chk("req_ready", 32'(req_ready), 32'(!busy && !flush && !hwpend));
`ifdef CACHE_STATS_EN
      if (!busy) begin
        chk("hit_count", hit_count, 32'(m_hits));
        chk("miss_count", miss_count, 32'(m_misses));
      end
      if (cyc == stats_lit_cyc) begin
        chk("lit_hit_count", hit_count, 32'd1);
        chk("lit_miss_count", miss_count, 32'd4);
      end
`endif
      if (flush) begin
        if (busy) hwpend = 1'b1;
        else model_clear_valid();
      end
      if (!busy && hwpend) begin
        model_clear_valid();
        hwpend = 1'b0;
      end

      if (mem_req_valid) begin
        if (emq.size() == 0) chk("mem_req_unexpected", 32'd1, 32'd0);
        else begin
          chk("mem_req_addr", 32'(mem_req_addr), 32'(emq[0]));
          if (mem_req_ready) void'(emq.pop_front());
        end
      end

      if (resp_valid) begin
        if (!busy) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          e = exq.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_hit", 32'(resp_hit), 32'(e.hit));
          if (e.hit) chk("hit_latency", 32'(cyc - e.acc), 32'd1);
          else if (fixed_mem) chk("miss_latency", 32'(cyc - e.acc), 32'd6);
          else chk("miss_latency_min", 32'((cyc - e.acc) >= 6), 32'd1);
          if (e.lit != 0) begin
            chk("lit_resp_hit", 32'(resp_hit), 32'(e.lit == 1));
            chk("lit_resp_data", resp_data, e.lit_d);
          end
        end
      end else if (busy) begin
        e = exq[0];
        if ((e.hit && (cyc - e.acc) >= 1) || (!e.hit && fixed_mem && (cyc - e.acc) >= 6) ||
            ((cyc - e.acc) > 400)) begin
          chk("resp_missing", 32'd0, 32'd1);
          void'(exq.pop_front());
          emq.delete();
        end
      end

      if (!busy && req_valid && req_ready) begin
        int a, tg, ix, hw, vw;
        a  = int'(req_addr);
        tg = a >> 3;
        ix = (a >> 1) & 3;
        hw = -1;
        for (int w = 1; w >= 0; w--)
          if (m_valid[ix][w] && m_tag[ix][w] == tg) hw = w;
        e.hit   = (hw >= 0);
        e.data  = 32'hA5A50000 | {16'h0, req_addr};
        e.acc   = cyc;
        e.lit   = lit_sel;
        e.lit_d = lit_data;
        if (hw >= 0) m_hits++;
        else begin
          m_misses++;
          vw = -1;
          for (int w = 1; w >= 0; w--)
            if (!m_valid[ix][w]) vw = w;
          if (vw < 0) begin
            vw = m_ptr[ix];
            m_ptr[ix] = (m_ptr[ix] + 1) % 2;
          end
          m_valid[ix][vw] = 1'b1;
          m_tag[ix][vw] = tg;
          for (int k = 0; k < 2; k++) emq.push_back(16'((a & ~1) + k));
        end
        exq.push_back(e);
      end
    end
  end

  // Memory: data = 0xA5A50000|addr; fixed mode gives one-cycle ready and response.
  initial begin : mem_model
    bit          hs, rs, pend;
    logic [15:0] hs_a, pa;
    int          cnt;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    pend = 1'b0;
    cnt  = 0;
    pa   = 16'h0;
    forever begin
      @(negedge clk);
      hs   = mem_req_valid && mem_req_ready && !rst;
      hs_a = mem_req_addr;
      rs   = rst;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (rs || rst) pend = 1'b0;
      else begin
        if (hs) begin
          pend = 1'b1;
          pa   = hs_a;
          cnt  = fixed_mem ? 1 : int'($urandom_range(1, 3));
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hA5A50000 | {16'h0, pa};
            pend = 1'b0;
          end
        end else if (!fixed_mem && $urandom_range(0, 7) == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = 32'hDEADBEEF;
        end
      end
      mem_req_ready = fixed_mem ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  task automatic do_read(input logic [15:0] a, input int lit, input logic [31:0] ld,
                         input int fl_at, input int rst_at);
    int  n;
    bit  got;
    lit_sel   = lit;
    lit_data  = ld;
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lit_sel   = 0;
    for (int c = 1; c < 420; c++) begin
      if (c == fl_at) flush = 1'b1;
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      got = resp_valid;
      @(posedge clk);
      #1;
      flush = 1'b0;
      rst   = 1'b0;
      if (got || c == rst_at) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 16'h0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_read(16'h0011, 2, 32'hA5A50011, 0, 0);
    do_read(16'h0010, 1, 32'hA5A50010, 0, 0);

    do_reset();
    do_read(16'h0000, 2, 32'hA5A50000, 0, 0);
    do_read(16'h0008, 2, 32'hA5A50008, 0, 0);
    do_read(16'h0010, 2, 32'hA5A50010, 0, 0);
    do_read(16'h0008, 1, 32'hA5A50008, 0, 0);
    do_read(16'h0000, 2, 32'hA5A50000, 0, 0);
    stats_lit_cyc = cyc + 1;
    @(posedge clk);
    #1;

    do_flush();
    do_read(16'h0010, 2, 32'hA5A50010, 0, 0);
    do_read(16'h0020, 2, 32'hA5A50020, 3, 0);
    do_read(16'h0020, 2, 32'hA5A50020, 0, 0);
    do_read(16'h0030, 2, 32'hA5A50030, 0, 2);
    do_read(16'h0030, 2, 32'hA5A50030, 0, 0);
    do_read(16'h0031, 1, 32'hA5A50031, 0, 0);

    fixed_mem = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      int fl, ra;
      a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 47));
      fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 8)) : 0;
      ra = ($urandom_range(0, 59) == 0) ? int'($urandom_range(1, 5)) : 0;
      do_read(a, 0, 32'h0, fl, ra);
      if ($urandom_range(0, 19) == 0) do_flush();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
